// File: rtl/coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl
//   Snooping memory bus controller between NCORES private L1 caches and one
//   shared RAM port. Arbitrates writebacks, coherent fills, plain fills and
//   instruction fetches (in that priority order, round-robin within a class),
//   runs a one-cycle MSI snoop for coherent fills, and turns a dirty snoop
//   hit into a cache-to-cache transfer with a concurrent RAM writeback.
//
// Ports
//   CLK, nRST                clock, asynchronous active-low reset
//   iREN/iaddr               per-core instruction fetch request / address
//   iwait/iload              per-core fetch stall (low = data valid) / data
//   dREN/dWEN/daddr/dstore   per-core dcache fill / writeback request
//   cctrans/ccwrite          coherent-fill marker / write intent or dirty flag
//   dwait/dload              per-core dcache stall (low = word done) / data
//   ccwait/ccinv/ccsnoopaddr snoop stall, invalidate, snoop address
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  shared RAM port
// ---------------------------------------------------------------------------
module coherence_bus_ctrl #(
    parameter int NCORES   = 2,
    parameter int BLKWORDS = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCORES-1:0]      iREN,
    input  logic [32*NCORES-1:0]   iaddr,
    output logic [NCORES-1:0]      iwait,
    output logic [32*NCORES-1:0]   iload,
    input  logic [NCORES-1:0]      dREN,
    input  logic [NCORES-1:0]      dWEN,
    input  logic [32*NCORES-1:0]   daddr,
    input  logic [32*NCORES-1:0]   dstore,
    input  logic [NCORES-1:0]      cctrans,
    input  logic [NCORES-1:0]      ccwrite,
    output logic [NCORES-1:0]      dwait,
    output logic [32*NCORES-1:0]   dload,
    output logic [NCORES-1:0]      ccwait,
    output logic [NCORES-1:0]      ccinv,
    output logic [32*NCORES-1:0]   ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate
);

    localparam int CW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int WW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {IDLE, IFETCH, WB, SNOOP, MEMLD, C2C} state_t;

    state_t          state_reg;
    logic [CW-1:0]   rr_reg;
    logic [CW-1:0]   gnt_reg;
    logic [CW-1:0]   src_reg;
    logic [WW-1:0]   wcnt_reg;

    // Per-core word views of the flattened buses
    logic [31:0] iaddr_w  [NCORES];
    logic [31:0] daddr_w  [NCORES];
    logic [31:0] dstore_w [NCORES];
    logic [31:0] iload_w  [NCORES];
    logic [31:0] dload_w  [NCORES];
    logic [31:0] snoop_w  [NCORES];

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_unpack
            assign iaddr_w[gi]               = iaddr[32*gi +: 32];
            assign daddr_w[gi]               = daddr[32*gi +: 32];
            assign dstore_w[gi]              = dstore[32*gi +: 32];
            assign iload[32*gi +: 32]        = iload_w[gi];
            assign dload[32*gi +: 32]        = dload_w[gi];
            assign ccsnoopaddr[32*gi +: 32]  = snoop_w[gi];
        end
    endgenerate

    // Returns {found, index}: first requester at or after ptr, wrapping.
    // Scanning offsets downwards lets the smallest offset win last.
    function automatic logic [CW:0] rr_pick(input logic [NCORES-1:0] req,
                                            input logic [CW-1:0]     ptr);
        logic [CW:0] res;
        int          idx;
        res = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NCORES) idx = idx - NCORES;
            if (req[idx]) res = {1'b1, idx[CW-1:0]};
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] next_core(input logic [CW-1:0] c);
        if (c == CW'(NCORES - 1)) return '0;
        return c + CW'(1);
    endfunction

    logic [CW:0] wb_pick, cf_pick, pf_pick, if_pick;
    logic        dirty_found;
    logic [CW-1:0] dirty_idx;
    logic        access;
    logic        last_word;

    assign access    = (ramstate == RAM_ACCESS);
    assign last_word = (wcnt_reg == WW'(BLKWORDS - 1));

    always_comb begin
        wb_pick = rr_pick(dWEN, rr_reg);
        cf_pick = rr_pick(dREN & cctrans, rr_reg);
        pf_pick = rr_pick(dREN & ~cctrans, rr_reg);
        if_pick = rr_pick(iREN, rr_reg);
    end

    // Lowest-indexed snooper reporting a dirty copy supplies the block
    always_comb begin
        dirty_found = 1'b0;
        dirty_idx   = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            if (k != int'(gnt_reg) && ccwrite[k]) begin
                dirty_found = 1'b1;
                dirty_idx   = CW'(k);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            rr_reg    <= '0;
            gnt_reg   <= '0;
            src_reg   <= '0;
            wcnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wcnt_reg <= '0;
                    if (wb_pick[CW]) begin
                        state_reg <= WB;
                        gnt_reg   <= wb_pick[CW-1:0];
                        rr_reg    <= next_core(wb_pick[CW-1:0]);
                    end else if (cf_pick[CW]) begin
                        state_reg <= SNOOP;
                        gnt_reg   <= cf_pick[CW-1:0];
                        rr_reg    <= next_core(cf_pick[CW-1:0]);
                    end else if (pf_pick[CW]) begin
                        state_reg <= MEMLD;
                        gnt_reg   <= pf_pick[CW-1:0];
                        rr_reg    <= next_core(pf_pick[CW-1:0]);
                    end else if (if_pick[CW]) begin
                        state_reg <= IFETCH;
                        gnt_reg   <= if_pick[CW-1:0];
                        rr_reg    <= next_core(if_pick[CW-1:0]);
                    end
                end
                IFETCH: begin
                    if (access) state_reg <= IDLE;
                end
                SNOOP: begin
                    if (dirty_found) begin
                        src_reg   <= dirty_idx;
                        state_reg <= C2C;
                    end else begin
                        state_reg <= MEMLD;
                    end
                end
                WB, MEMLD, C2C: begin
                    if (access) begin
                        wcnt_reg <= wcnt_reg + WW'(1);
                        if (last_word) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int k = 0; k < NCORES; k++) begin
            iload_w[k] = '0;
            dload_w[k] = '0;
            snoop_w[k] = '0;
        end
        case (state_reg)
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr_w[gnt_reg];
                if (access) begin
                    iwait[gnt_reg]   = 1'b0;
                    iload_w[gnt_reg] = ramload;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_w[gnt_reg];
                ramstore = dstore_w[gnt_reg];
                if (access) dwait[gnt_reg] = 1'b0;
            end
            SNOOP: begin
                for (int k = 0; k < NCORES; k++) begin
                    if (k != int'(gnt_reg)) begin
                        ccwait[k]  = 1'b1;
                        ccinv[k]   = ccwrite[gnt_reg];
                        snoop_w[k] = daddr_w[gnt_reg];
                    end
                end
            end
            MEMLD: begin
                ramREN  = 1'b1;
                ramaddr = daddr_w[gnt_reg];
                if (access) begin
                    dwait[gnt_reg]   = 1'b0;
                    dload_w[gnt_reg] = ramload;
                end
            end
            C2C: begin
                // Dirty owner feeds the requester and RAM in the same cycle
                for (int k = 0; k < NCORES; k++) begin
                    if (k != int'(gnt_reg)) ccwait[k] = 1'b1;
                end
                ramWEN           = 1'b1;
                ramaddr          = daddr_w[src_reg];
                ramstore         = dstore_w[src_reg];
                dload_w[gnt_reg] = dstore_w[src_reg];
                if (access) begin
                    dwait[gnt_reg] = 1'b0;
                    dwait[src_reg] = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_ctrl
//   Transaction-level reference model of the bus controller for NCORES=4,
//   BLKWORDS=4. The bench plays every cache and the RAM, keeps a pending
//   request list per core, decides each grant from the priority classes and
//   a round-robin pointer, and then checks every cycle of the transaction
//   against the timing rules (IDLE, optional SNOOP, then one or more RAM words).
// ---------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

    localparam int NC = 4;
    localparam int BW = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERR = 2'd3;
    localparam int K_NONE = 0, K_IF = 1, K_WB = 2, K_SN = 3, K_MEM = 4, K_C2C = 5;
    localparam logic [31:0] ALL = (32'd1 << NC) - 32'd1;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NC-1:0]     iREN, dREN, dWEN, cctrans, ccwrite;
    logic [32*NC-1:0]  iaddr, daddr, dstore;
    logic [NC-1:0]     iwait, dwait, ccwait, ccinv;
    logic [32*NC-1:0]  iload, dload, ccsnoopaddr;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.NCORES(NC), .BLKWORDS(BW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pending requests per core
    bit          ip [NC];  logic [31:0] ia [NC];
    bit          wp [NC];  logic [31:0] wa [NC];  logic [31:0] wd [NC][BW];
    bit          fp [NC];  bit fcc [NC];  bit fw [NC];  logic [31:0] fa [NC];

    int          rr = 0;
    int          cur_kind = K_NONE, cur_g = 0, cur_s = 0, cur_w = 0;
    logic [NC-1:0] dirty;
    logic [31:0] sd [BW];
    int          fixed_busy  = -1;
    int          fixed_dirty = -1;

    function automatic logic [31:0] bitm(input int k);
        return 32'd1 << k;
    endfunction

    function automatic logic [31:0] rand_addr(input int k);
        return ($urandom & 32'hFFFF_F000) | (32'(k) << 8);
    endfunction

    function automatic bit wants(input int cls, input int k);
        case (cls)
            1: return wp[k];
            2: return fp[k] && fcc[k];
            3: return fp[k] && !fcc[k];
            default: return ip[k];
        endcase
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < NC; k++) if (ip[k] || wp[k] || fp[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_all();
        for (int k = 0; k < NC; k++) begin
            ip[k] = 0; wp[k] = 0; fp[k] = 0; fcc[k] = 0; fw[k] = 0;
        end
    endtask

    // Present the caches' view of the bus for the current transaction phase
    task automatic drive();
        for (int k = 0; k < NC; k++) begin
            iREN[k]    = ip[k];
            dWEN[k]    = wp[k];
            dREN[k]    = fp[k];
            cctrans[k] = fp[k] && fcc[k];
            ccwrite[k] = fw[k];
            iaddr[32*k +: 32]  = ia[k];
            daddr[32*k +: 32]  = wp[k] ? wa[k] : fa[k];
            dstore[32*k +: 32] = 32'h0;
        end
        if (cur_kind == K_WB) begin
            daddr[32*cur_g +: 32]  = wa[cur_g] + 32'(4 * cur_w);
            dstore[32*cur_g +: 32] = wd[cur_g][cur_w];
        end
        if (cur_kind == K_SN || cur_kind == K_MEM || cur_kind == K_C2C)
            daddr[32*cur_g +: 32] = fa[cur_g] + 32'(4 * cur_w);
        if (cur_kind == K_SN)
            for (int k = 0; k < NC; k++) if (k != cur_g) ccwrite[k] = dirty[k];
        if (cur_kind == K_C2C) begin
            daddr[32*cur_s +: 32]  = fa[cur_g] + 32'(4 * cur_w);
            dstore[32*cur_s +: 32] = sd[cur_w];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iwait"},  32'(iwait),  ALL);
        check({tag, "_dwait"},  32'(dwait),  ALL);
        check({tag, "_ccwait"}, 32'(ccwait), 32'h0);
        check({tag, "_ccinv"},  32'(ccinv),  32'h0);
        check({tag, "_ramren"}, 32'(ramREN), 32'h0);
        check({tag, "_ramwen"}, 32'(ramWEN), 32'h0);
        check({tag, "_ramaddr"}, ramaddr, 32'h0);
        check({tag, "_ramstore"}, ramstore, 32'h0);
        for (int k = 0; k < NC; k++) begin
            check({tag, "_iload"}, iload[32*k +: 32], 32'h0);
            check({tag, "_dload"}, dload[32*k +: 32], 32'h0);
            check({tag, "_snpaddr"}, ccsnoopaddr[32*k +: 32], 32'h0);
        end
    endtask

    // One complete arbitrated transaction, checked cycle by cycle
    task automatic run_txn(output int g_out);
        int g, cls, kind, s, nb;
        logic [31:0] eaddr, estore, eiw, edw;
        bit acc;
        g = -1; cls = 0; s = -1;
        for (int c = 1; c <= 4 && g < 0; c++)
            for (int i = 0; i < NC && g < 0; i++)
                if (wants(c, (rr + i) % NC)) begin g = (rr + i) % NC; cls = c; end
        g_out = g;
        if (g < 0) return;

        cur_kind = K_NONE; ramstate = FREE; ramload = $urandom;
        drive(); #1;
        check("idle_ramren", 32'(ramREN), 32'h0);
        check("idle_ramwen", 32'(ramWEN), 32'h0);
        check("idle_dwait",  32'(dwait),  ALL);
        check("idle_iwait",  32'(iwait),  ALL);
        check("idle_ccwait", 32'(ccwait), 32'h0);
        tick();
        rr = (g + 1) % NC;
        kind = (cls == 1) ? K_WB : (cls == 2) ? K_SN : (cls == 3) ? K_MEM : K_IF;

        if (kind == K_SN) begin
            for (int k = 0; k < NC; k++)
                dirty[k] = (fixed_dirty >= 0) ? fixed_dirty[k] : ($urandom_range(0, 3) == 0);
            dirty[g] = 1'b0;
            for (int w = 0; w < BW; w++)
                sd[w] = (fixed_dirty >= 0) ? 32'(17 * (w + 1)) : $urandom;
            cur_kind = K_SN; cur_g = g; cur_w = 0;
            drive(); #1;
            check("snoop_ccwait", 32'(ccwait), ALL & ~bitm(g));
            check("snoop_ccinv",  32'(ccinv),  fw[g] ? (ALL & ~bitm(g)) : 32'h0);
            check("snoop_ramren", 32'(ramREN), 32'h0);
            check("snoop_ramwen", 32'(ramWEN), 32'h0);
            check("snoop_dwait",  32'(dwait),  ALL);
            for (int k = 0; k < NC; k++)
                if (k != g) check("snoop_addr", ccsnoopaddr[32*k +: 32], fa[g]);
            tick();
            for (int k = NC - 1; k >= 0; k--) if (dirty[k]) s = k;
            kind = (s >= 0) ? K_C2C : K_MEM;
        end

        $display("TXN %0d kind=%0d core=%0d src=%0d rr_next=%0d", txn_no, kind, g, s, rr);
        txn_no++;

        for (int w = 0; w < ((kind == K_IF) ? 1 : BW); w++) begin
            nb = (fixed_busy >= 0) ? fixed_busy : $urandom_range(0, 2);
            for (int b = 0; b <= nb; b++) begin
                acc = (b == nb);
                cur_kind = kind; cur_g = g; cur_s = s; cur_w = w;
                ramstate = acc ? ACCESS : ($urandom_range(0, 1) ? BUSY : ERR);
                ramload  = $urandom;
                drive(); #1;
                case (kind)
                    K_IF:    eaddr = ia[g];
                    K_WB:    eaddr = wa[g] + 32'(4 * w);
                    default: eaddr = fa[g] + 32'(4 * w);
                endcase
                estore = (kind == K_WB) ? wd[g][w] : sd[w];
                check("ram_ren", 32'(ramREN), (kind == K_IF || kind == K_MEM) ? 32'h1 : 32'h0);
                check("ram_wen", 32'(ramWEN), (kind == K_WB || kind == K_C2C) ? 32'h1 : 32'h0);
                check("ram_addr", ramaddr, eaddr);
                if (kind == K_WB || kind == K_C2C) check("ram_store", ramstore, estore);
                eiw = ALL; edw = ALL;
                if (acc) begin
                    if (kind == K_IF) eiw = eiw & ~bitm(g);
                    else edw = edw & ~bitm(g);
                    if (kind == K_C2C) edw = edw & ~bitm(s);
                end
                check("iwait", 32'(iwait), eiw);
                check("dwait", 32'(dwait), edw);
                check("xfer_ccwait", 32'(ccwait), (kind == K_C2C) ? (ALL & ~bitm(g)) : 32'h0);
                if (acc && kind == K_IF)  check("iload", iload[32*g +: 32], ramload);
                if (acc && kind == K_MEM) check("dload_mem", dload[32*g +: 32], ramload);
                if (acc && kind == K_C2C) check("dload_c2c", dload[32*g +: 32], sd[w]);
                tick();
            end
        end
        if (kind == K_IF) ip[g] = 0;
        else if (kind == K_WB) wp[g] = 0;
        else fp[g] = 0;
        cur_kind = K_NONE; ramstate = FREE;
    endtask

    task automatic add_random();
        for (int k = 0; k < NC; k++) begin
            if (!ip[k] && $urandom_range(0, 2) == 0) begin ip[k] = 1; ia[k] = rand_addr(k); end
            if (!wp[k] && $urandom_range(0, 4) == 0) begin
                wp[k] = 1; wa[k] = rand_addr(k);
                for (int w = 0; w < BW; w++) wd[k][w] = $urandom;
            end
            if (!fp[k] && $urandom_range(0, 2) == 0) begin
                fp[k] = 1; fcc[k] = ($urandom_range(0, 3) != 0);
                fw[k] = $urandom_range(0, 1); fa[k] = rand_addr(k);
            end
        end
    endtask

    initial begin
        int g;
        clear_all();
        for (int k = 0; k < NC; k++) begin ia[k] = 0; wa[k] = 0; fa[k] = 0; end
        ramstate = FREE; ramload = 0; cur_kind = K_NONE;
        nRST = 1'b0;
        drive(); #1;
        check_reset_outputs("reset");
        tick(); tick();
        nRST = 1'b1;

        // Single ifetch with two waiting cycles before ACCESS
        fixed_busy = 2;
        ip[0] = 1; ia[0] = 32'h100;
        run_txn(g);
        fixed_busy = -1;

        // Dirty snoop hit: core0 supplies core1's write fill of 0x200
        fixed_dirty = 1;
        fp[1] = 1; fcc[1] = 1; fw[1] = 1; fa[1] = 32'h200;
        run_txn(g);

        // Priority within one core and across cores
        fixed_dirty = 0;
        ip[0] = 1; ia[0] = 32'h300;
        wp[1] = 1; wa[1] = 32'h400;
        for (int w = 0; w < BW; w++) wd[1][w] = $urandom;
        fp[1] = 1; fcc[1] = 1; fw[1] = 0; fa[1] = 32'h500;
        repeat (3) run_txn(g);

        // Two cores holding coherent fills continuously
        fp[0] = 1; fcc[0] = 1; fw[0] = 0; fa[0] = 32'h1000;
        fp[1] = 1; fcc[1] = 1; fw[1] = 0; fa[1] = 32'h2000;
        for (int t = 0; t < 4; t++) begin
            run_txn(g);
            if (t < 2 && g >= 0) fp[g] = 1;
        end

        // Reset during the second word of a plain fill on core2
        clear_all();
        fp[2] = 1; fcc[2] = 0; fa[2] = 32'h700;
        cur_kind = K_NONE; drive(); #1;
        tick();
        cur_kind = K_MEM; cur_g = 2; cur_w = 0;
        ramstate = ACCESS; ramload = 32'hCAFE0000;
        drive(); #1;
        check("pre_rst_w0_dwait", 32'(dwait), ALL & ~bitm(2));
        tick();
        cur_w = 1; drive(); #1;
        check("pre_rst_w1_dwait", 32'(dwait), ALL & ~bitm(2));
        nRST = 1'b0; #1;
        check_reset_outputs("rst_mid");
        tick();
        nRST = 1'b1;
        rr = 0; cur_kind = K_NONE; ramstate = FREE;
        clear_all();
        for (int k = 0; k < NC; k++) begin
            fp[k] = 1; fcc[k] = 1; fw[k] = 0; fa[k] = 32'h8000 + 32'(k * 32'h100);
        end
        repeat (4) run_txn(g);

        // Randomized traffic
        fixed_dirty = -1;
        for (int t = 0; t < 200; t++) begin
            add_random();
            run_txn(g);
        end
        for (int t = 0; t < 100 && any_pending(); t++) run_txn(g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

N-core snooping memory bus controller between the per-core L1 caches and the single shared RAM port. It arbitrates instruction fetches, dcache writebacks and coherent dcache block fills across `NCORES` cores. It runs an MSI snoop phase for every coherent fill and services a dirty snoop hit as a cache-to-cache transfer with concurrent RAM writeback. It generalises the fixed two-core, two-word bus controller to any core count and block size, and adds round-robin fairness.

## Interface
- `NCORES`, 2: number of cores; legal range 2..8.
- `BLKWORDS`, 2: 32-bit words per dcache block; legal range 1..8.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `iREN` in NCORES: icache read request, one bit per core.
- `iaddr` in 32*NCORES: icache word address; core k occupies bits [32k+31:32k].
- `iwait` out NCORES: low for exactly one cycle when `iload` is valid.
- `iload` out 32*NCORES: fetched instruction.
- `dREN`, `dWEN` in NCORES: dcache read request (fill) and write request (writeback).
- `daddr`, `dstore` in 32*NCORES: dcache word address and write data.
- `cctrans` in NCORES: marks a dcache request as a coherent fill (snoop required).
- `ccwrite` in NCORES: on the requester, the fill is for write (invalidate others); on a snooper, it holds the snooped block dirty.
- `dwait` out NCORES: low for one cycle per completed word.
- `dload` out 32*NCORES: fill data.
- `ccwait` out NCORES: snoop in progress; the core must respond and stall.
- `ccinv` out NCORES: invalidate the snooped block.
- `ccsnoopaddr` out 32*NCORES: snoop address, identical for all snooped cores.
- `ramREN`, `ramWEN` out 1: RAM read and write enables; never both high.
- `ramaddr`, `ramstore` out 32: RAM address and write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3. ACCESS means the current word is done.

## Operation
- States: IDLE, IFETCH, WB, SNOOP, MEMLD, C2C. A word counter `wcnt` (width clog2(BLKWORDS), minimum 1) and a registered grant `gnt` are held.
- IDLE arbitration classes, highest first:
  1. dWEN (writeback).
  2. dREN with cctrans.
  3. dREN without cctrans (plain fill).
  4. iREN.
- Within a class, the winner is the first requesting core at or after the round-robin pointer `rr`, wrapping modulo NCORES.
- On grant: `rr` ← `gnt`+1 (mod NCORES), `wcnt` ← 0. The next state is WB, SNOOP, MEMLD or IFETCH for classes 1 to 4 respectively.
- IFETCH: `ramREN`=1, `ramaddr`=`iaddr[gnt]`. On ACCESS, `iwait[gnt]`=0 and `iload[gnt]`=`ramload`, then go to IDLE.
- WB: `ramWEN`=1, `ramaddr`=`daddr[gnt]`, `ramstore`=`dstore[gnt]`.
  - On ACCESS, `dwait[gnt]`=0 for that cycle and `wcnt`++.
  - After word BLKWORDS-1, go to IDLE.
  - The cache advances `daddr` by 4 after each word.
- SNOOP, exactly one cycle:
  - For every core k≠gnt: `ccwait[k]`=1, `ccsnoopaddr[k]`=`daddr[gnt]`, `ccinv[k]`=`ccwrite[gnt]`.
  - At the end of the cycle, sample `ccwrite[k]` for k≠gnt. If any is high, the lowest such index becomes `src` and the next state is C2C. Otherwise the next state is MEMLD.
- MEMLD: `ramREN`=1, `ramaddr`=`daddr[gnt]`. On ACCESS, `dload[gnt]`=`ramload`, `dwait[gnt]`=0 and `wcnt`++. After the last word, go to IDLE.
- C2C:
  - `ccwait[k]` stays high for all k≠gnt.
  - `ramWEN`=1, `ramaddr`=`daddr[src]`, `ramstore`=`dstore[src]`, `dload[gnt]`=`dstore[src]`.
  - On ACCESS, `dwait[gnt]`=0, `dwait[src]`=0 and `wcnt`++. After the last word, go to IDLE.
- A dcache fill without cctrans is serviced as a plain MEMLD with no snoop.
- ERROR is treated like BUSY: the controller keeps waiting.

## Timing
- Reset values, asynchronous on nRST low:
  - State IDLE; `rr`=0, `gnt`=0, `wcnt`=0, `src`=0.
  - `iwait` and `dwait` all 1.
  - `ccwait`, `ccinv`, `ramREN`, `ramWEN`, `ramaddr`, `ramstore` all 0.
  - `iload`, `dload` and `ccsnoopaddr` all 0.
- Reset mid-transaction aborts immediately. No partial completion pulse is emitted.
- Outputs are combinational from registered state and the current inputs. Grant takes effect one cycle after the request is seen in IDLE.
- Minimum latencies with `ramstate`=ACCESS on the first RAM cycle:
  - Ifetch: 2 cycles from the request to `iwait` low.
  - Coherent fill: 3 cycles from the request to the first-word `dwait` low.
  - Each further word: 1 cycle.
- The controller returns to IDLE on the cycle after the final word. A request held continuously by the same core is re-arbitrated there and loses to any other pending request of the same class.
- A requester dropping its request mid-block is undefined. Caches must hold the request until the last `dwait` low.

## Test plan
- Single ifetch: core0 `iREN`=1, `iaddr`=0x100, RAM returns 0xDEADBEEF after 2 BUSY cycles. Required: `iwait[0]` low in cycle 4 only, with `iload[0]`=0xDEADBEEF.
- Round-robin: cores 0 and 1 hold `dREN`+`cctrans` continuously with no snoop hits. Required: grants alternate 0,1,0,1, with each block taking BLKWORDS `dwait` pulses.
- Dirty snoop hit: core1 requests a fill of 0x200 with `ccwrite`=1, and core0 asserts `ccwrite` in SNOOP with `dstore`=0x11,0x22. Required: `ccinv[0]`=1; `dload[1]`=0x11 then 0x22; RAM writes 0x200←0x11 and 0x204←0x22.
- Priority: the same cycle carries core0 `iREN`, core1 `dREN`+`cctrans` and core1 `dWEN`. Required: service order WB(core1), then SNOOP fill(core1), then IFETCH(core0).
- Reset mid-MEMLD after word 0: nRST low. Required: all outputs take reset values immediately, and after release the first grant goes to the lowest requesting core.
- `NCORES`=4, `BLKWORDS`=4: all four cores request fills with a clean snoop. Required: grant order 0,1,2,3; 16 RAM reads; `ccwait` high on exactly the three non-requesting cores during each SNOOP.
